// File: rtl/dmem_check_pkg.sv
// Shared types and helpers for the data-memory write scoreboard.
package dmem_check_pkg;

  localparam int unsigned MAX_DATA_WIDTH = 256;
  localparam int unsigned MAX_BE_WIDTH   = MAX_DATA_WIDTH / 8;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_PASS,
    S_FAIL
  } state_e;

  typedef enum logic [2:0] {
    FC_NONE,
    FC_BAD_ADDR,
    FC_BAD_DATA,
    FC_TIMEOUT,
    FC_NO_EXPECT
  } fail_code_e;

  // Expands byte enables into a bit mask; callers truncate to their data width.
  function automatic logic [MAX_DATA_WIDTH-1:0] be_to_mask(input logic [MAX_BE_WIDTH-1:0] be);
    logic [MAX_DATA_WIDTH-1:0] m;
    m = '0;
    for (int i = 0; i < int'(MAX_BE_WIDTH); i++) begin
      m[i*8 +: 8] = {8{be[i]}};
    end
    return m;
  endfunction

endpackage

// File: rtl/sb_entry_match.sv
// Compares one expected-table entry against the live store: address equality and
// byte-enable-masked data equality.
module sb_entry_match
  import dmem_check_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic [ADDR_WIDTH-1:0]   i_exp_addr,
  input  logic [DATA_WIDTH-1:0]   i_exp_data,
  input  logic [ADDR_WIDTH-1:0]   i_wr_addr,
  input  logic [DATA_WIDTH-1:0]   i_wr_data,
  input  logic [DATA_WIDTH/8-1:0] i_wr_be,
  output logic                    o_addr_eq_c,
  output logic                    o_match_c
);

  logic [DATA_WIDTH-1:0] w_mask;

  assign w_mask      = DATA_WIDTH'(be_to_mask(MAX_BE_WIDTH'(i_wr_be)));
  assign o_addr_eq_c = (i_exp_addr == i_wr_addr);
  assign o_match_c   = o_addr_eq_c && ((i_wr_data & w_mask) == (i_exp_data & w_mask));

endmodule

// File: rtl/dmem_write_scoreboard.sv
// Checks data-memory stores against a loaded table of expected (addr, data) pairs,
// in order or any order, with sticky pass/fail status, fail code and timeout.
module dmem_write_scoreboard
  import dmem_check_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned NUM_EXPECT     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 500,
  parameter bit          ORDERED        = 1'b1,
  parameter bit          ALLOW_EXTRA    = 1'b0,
  localparam int unsigned IDX_W = (NUM_EXPECT > 1) ? $clog2(NUM_EXPECT) : 1,
  localparam int unsigned CNT_W = $clog2(NUM_EXPECT + 1),
  localparam int unsigned CYC_W = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_clear,
  input  logic                    i_load_valid,
  input  logic [IDX_W-1:0]        i_load_idx,
  input  logic [ADDR_WIDTH-1:0]   i_load_addr,
  input  logic [DATA_WIDTH-1:0]   i_load_data,
  input  logic                    i_start,
  input  logic                    i_wr_en,
  input  logic [ADDR_WIDTH-1:0]   i_wr_addr,
  input  logic [DATA_WIDTH-1:0]   i_wr_data,
  input  logic [DATA_WIDTH/8-1:0] i_wr_be,
  output logic                    o_busy,
  output logic                    o_done,
  output logic                    o_pass,
  output logic [2:0]              o_fail_code,
  output logic [CNT_W-1:0]        o_match_count,
  output logic [CYC_W-1:0]        o_cycle_count,
  output logic [ADDR_WIDTH-1:0]   o_fail_addr,
  output logic [DATA_WIDTH-1:0]   o_fail_data
);

  state_e                r_state;
  state_e                w_state_nxt;
  fail_code_e            r_fail_code;
  fail_code_e            w_fc_nxt;
  logic [ADDR_WIDTH-1:0] r_exp_addr [NUM_EXPECT];
  logic [DATA_WIDTH-1:0] r_exp_data [NUM_EXPECT];
  logic [CNT_W-1:0]      r_n;
  logic [NUM_EXPECT-1:0] r_hit;
  logic [CNT_W-1:0]      r_match_count;
  logic [CYC_W-1:0]      r_cycle_count;
  logic [ADDR_WIDTH-1:0] r_fail_addr;
  logic [DATA_WIDTH-1:0] r_fail_data;

  logic [NUM_EXPECT-1:0] w_addr_eq;
  logic [NUM_EXPECT-1:0] w_match;
  logic [NUM_EXPECT-1:0] w_valid;
  logic [NUM_EXPECT-1:0] w_cand;
  logic [NUM_EXPECT-1:0] w_hit_sel;
  logic [NUM_EXPECT-1:0] w_hit_set;
  logic                  w_any_addr;
  logic                  w_cur_match;
  logic                  w_cur_addr_eq;
  logic [IDX_W-1:0]      w_ptr_idx;
  logic [CNT_W-1:0]      w_count_inc;
  logic [CYC_W-1:0]      w_cyc_next;
  logic [CNT_W-1:0]      w_load_n;
  logic                  w_restart;
  logic                  w_cyc_inc;
  logic                  w_match_inc;
  logic                  w_cap_wr;

  for (genvar gi = 0; gi < int'(NUM_EXPECT); gi++) begin : g_entry
    sb_entry_match #(
      .ADDR_WIDTH(ADDR_WIDTH),
      .DATA_WIDTH(DATA_WIDTH)
    ) u_match (
      .i_exp_addr (r_exp_addr[gi]),
      .i_exp_data (r_exp_data[gi]),
      .i_wr_addr  (i_wr_addr),
      .i_wr_data  (i_wr_data),
      .i_wr_be    (i_wr_be),
      .o_addr_eq_c(w_addr_eq[gi]),
      .o_match_c  (w_match[gi])
    );
    assign w_valid[gi] = (CNT_W'(gi) < r_n);
  end

  // In ordered mode match_count doubles as the pointer to the next expected entry.
  assign w_ptr_idx     = IDX_W'(r_match_count);
  assign w_cur_match   = w_match[w_ptr_idx];
  assign w_cur_addr_eq = w_addr_eq[w_ptr_idx];
  assign w_any_addr    = |(w_addr_eq & w_valid);
  assign w_cand        = w_match & w_valid & ~r_hit;
  assign w_hit_sel     = w_cand & (~w_cand + NUM_EXPECT'(1));
  assign w_count_inc   = r_match_count + CNT_W'(1);
  assign w_cyc_next    = r_cycle_count + CYC_W'(1);
  assign w_load_n      = CNT_W'(i_load_idx) + CNT_W'(1);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Write decisions take priority over timeout, so a final match on the last cycle passes.
  always_comb begin
    w_state_nxt = r_state;
    w_fc_nxt    = r_fail_code;
    w_restart   = 1'b0;
    w_cyc_inc   = 1'b0;
    w_match_inc = 1'b0;
    w_hit_set   = '0;
    w_cap_wr    = 1'b0;
    if (i_start) begin
      w_restart = 1'b1;
      if (r_n == '0) begin
        w_state_nxt = S_FAIL;
        w_fc_nxt    = FC_NO_EXPECT;
      end else begin
        w_state_nxt = S_RUN;
        w_fc_nxt    = FC_NONE;
      end
    end else if (r_state == S_RUN) begin
      w_cyc_inc = 1'b1;
      if (i_wr_en) begin
        if (ORDERED) begin
          if (w_cur_match) begin
            w_match_inc = 1'b1;
            if (w_count_inc == r_n) w_state_nxt = S_PASS;
          end else if (w_cur_addr_eq) begin
            w_state_nxt = S_FAIL;
            w_fc_nxt    = FC_BAD_DATA;
            w_cap_wr    = 1'b1;
          end else if (!(ALLOW_EXTRA && !w_any_addr)) begin
            w_state_nxt = S_FAIL;
            w_fc_nxt    = FC_BAD_ADDR;
            w_cap_wr    = 1'b1;
          end
        end else begin
          if (|w_cand) begin
            w_hit_set   = w_hit_sel;
            w_match_inc = 1'b1;
            if (w_count_inc == r_n) w_state_nxt = S_PASS;
          end else if (w_any_addr) begin
            w_state_nxt = S_FAIL;
            w_fc_nxt    = FC_BAD_DATA;
            w_cap_wr    = 1'b1;
          end else if (!ALLOW_EXTRA) begin
            w_state_nxt = S_FAIL;
            w_fc_nxt    = FC_BAD_ADDR;
            w_cap_wr    = 1'b1;
          end
        end
      end
      if ((w_state_nxt == S_RUN) && (w_cyc_next == CYC_W'(TIMEOUT_CYCLES))) begin
        w_state_nxt = S_FAIL;
        w_fc_nxt    = FC_TIMEOUT;
      end
    end
  end

  // Table and run counters; the table is frozen while a run is in progress.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < int'(NUM_EXPECT); i++) begin
        r_exp_addr[i] <= '0;
        r_exp_data[i] <= '0;
      end
      r_n           <= '0;
      r_hit         <= '0;
      r_match_count <= '0;
      r_cycle_count <= '0;
      r_fail_addr   <= '0;
      r_fail_data   <= '0;
      r_fail_code   <= FC_NONE;
    end else begin
      if (r_state != S_RUN) begin
        if (i_load_valid && (32'(i_load_idx) < NUM_EXPECT)) begin
          r_exp_addr[i_load_idx] <= i_load_addr;
          r_exp_data[i_load_idx] <= i_load_data;
        end
        if (i_clear) begin
          r_n <= '0;
        end else if (i_load_valid && (w_load_n > r_n)) begin
          r_n <= w_load_n;
        end
      end
      if (w_restart) begin
        r_hit         <= '0;
        r_match_count <= '0;
        r_cycle_count <= '0;
        r_fail_addr   <= '0;
        r_fail_data   <= '0;
      end else begin
        r_hit <= r_hit | w_hit_set;
        if (w_cyc_inc) r_cycle_count <= w_cyc_next;
        if (w_match_inc) r_match_count <= w_count_inc;
        if (w_cap_wr) begin
          r_fail_addr <= i_wr_addr;
          r_fail_data <= i_wr_data;
        end
      end
      r_fail_code <= w_fc_nxt;
    end
  end

  assign o_busy        = (r_state == S_RUN);
  assign o_done        = (r_state == S_PASS) || (r_state == S_FAIL);
  assign o_pass        = (r_state == S_PASS);
  assign o_fail_code   = r_fail_code;
  assign o_match_count = r_match_count;
  assign o_cycle_count = r_cycle_count;
  assign o_fail_addr   = r_fail_addr;
  assign o_fail_data   = r_fail_data;

endmodule

// File: tb/tb_dmem_write_scoreboard.sv
// Directed bench: three scoreboard variants (ordered, unordered, ordered+extra)
// share one stimulus stream; each is checked against hand-computed results.
module tb_dmem_write_scoreboard;

  localparam int unsigned TO    = 40;
  localparam int unsigned CNT_W = 4;
  localparam int unsigned CYC_W = 6;
  localparam int NDUT = 3;  // 0: ordered, 1: unordered, 2: ordered + allow extra

  logic        clk;
  logic        rst;
  logic        clear;
  logic        load_valid;
  logic [2:0]  load_idx;
  logic [31:0] load_addr;
  logic [31:0] load_data;
  logic        start;
  logic        wr_en;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;
  logic [3:0]  wr_be;

  logic             busy [NDUT];
  logic             done [NDUT];
  logic             pass [NDUT];
  logic [2:0]       fc   [NDUT];
  logic [CNT_W-1:0] mc   [NDUT];
  logic [CYC_W-1:0] cc   [NDUT];
  logic [31:0]      fa   [NDUT];
  logic [31:0]      fd   [NDUT];

  int n_checks = 0;
  int n_errors = 0;

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    dmem_write_scoreboard #(
      .ADDR_WIDTH(32), .DATA_WIDTH(32), .NUM_EXPECT(8), .TIMEOUT_CYCLES(TO),
      .ORDERED(g != 1), .ALLOW_EXTRA(g == 2)
    ) u_dut (
      .i_clk(clk), .i_rst(rst), .i_clear(clear), .i_load_valid(load_valid),
      .i_load_idx(load_idx), .i_load_addr(load_addr), .i_load_data(load_data),
      .i_start(start), .i_wr_en(wr_en), .i_wr_addr(wr_addr), .i_wr_data(wr_data),
      .i_wr_be(wr_be), .o_busy(busy[g]), .o_done(done[g]), .o_pass(pass[g]),
      .o_fail_code(fc[g]), .o_match_count(mc[g]), .o_cycle_count(cc[g]),
      .o_fail_addr(fa[g]), .o_fail_data(fd[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic load(input logic [2:0] idx, input logic [31:0] a, input logic [31:0] d);
    load_valid = 1'b1; load_idx = idx; load_addr = a; load_data = d;
    tick();
    load_valid = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1; tick(); clear = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1; tick(); start = 1'b0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be = 4'hF);
    wr_en = 1'b1; wr_addr = a; wr_data = d; wr_be = be;
    tick();
    wr_en = 1'b0;
  endtask

  // Status of one DUT: {done, pass, fail_code}
  task automatic check_status(input string tag, input int k, input logic [31:0] exp);
    check(tag, {27'd0, done[k], pass[k], fc[k]}, exp);
  endtask

  localparam logic [31:0] ST_PASS    = 32'h18;  // done=1 pass=1 FC_NONE
  localparam logic [31:0] ST_BADADDR = 32'h11;
  localparam logic [31:0] ST_BADDATA = 32'h12;
  localparam logic [31:0] ST_TIMEOUT = 32'h13;
  localparam logic [31:0] ST_NOEXP   = 32'h14;
  localparam logic [31:0] ST_RUN     = 32'h00;

  initial begin
    rst = 1'b1; clear = 1'b0; load_valid = 1'b0; load_idx = '0; load_addr = '0;
    load_data = '0; start = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0; wr_be = '0;
    tick(2);
    rst = 1'b0;

    check("reset_busy", 32'(busy[0]), 0);
    check_status("reset_status", 0, 32'h0);
    check("reset_mc", 32'(mc[0]), 0);
    check("reset_cc", 32'(cc[0]), 0);
    check("reset_fa", fa[0], 0);

    // Single entry, write on RUN cycle 10
    load(3'd0, 32'd100, 32'd25);
    do_start();
    check("start_busy", 32'(busy[0]), 1);
    check("start_cc", 32'(cc[0]), 0);
    tick(10);
    check("pre_wr_cc", 32'(cc[0]), 10);
    wr(32'd100, 32'd25);
    check_status("single_pass", 0, ST_PASS);
    check("single_mc", 32'(mc[0]), 1);
    check("single_cc", 32'(cc[0]), 11);
    check_status("single_pass_unord", 1, ST_PASS);
    tick(3);
    check("cc_frozen", 32'(cc[0]), 11);

    // Two entries, out-of-order write
    do_clear();
    load(3'd0, 32'd96, 32'd7);
    load(3'd1, 32'd100, 32'd25);
    do_start();
    wr(32'd100, 32'd25);
    check_status("ord_badaddr", 0, ST_BADADDR);
    check("ord_badaddr_fa", fa[0], 100);
    check("ord_badaddr_fd", fd[0], 25);
    check_status("unord_first_run", 1, ST_RUN);
    check("unord_first_busy", 32'(busy[1]), 1);
    check("unord_first_mc", 32'(mc[1]), 1);
    check_status("extra_known_addr", 2, ST_BADADDR);
    wr(32'd96, 32'd7);
    check_status("unord_pass", 1, ST_PASS);
    check("unord_pass_mc", 32'(mc[1]), 2);
    check_status("ord_sticky", 0, ST_BADADDR);

    // Unordered bad data on second write
    do_start();
    wr(32'd100, 32'd25);
    wr(32'd96, 32'd8);
    check_status("unord_baddata", 1, ST_BADDATA);
    check("unord_baddata_fd", fd[1], 8);
    check("unord_baddata_fa", fa[1], 96);

    // Same hit twice in unordered mode is a data failure
    do_start();
    wr(32'd100, 32'd25);
    wr(32'd100, 32'd25);
    check_status("unord_rehit", 1, ST_BADDATA);

    // In-order sequence passes everywhere
    do_start();
    wr(32'd96, 32'd7);
    check("ord_mid_mc", 32'(mc[0]), 1);
    wr(32'd100, 32'd25);
    check_status("ord_inorder_pass", 0, ST_PASS);
    check("ord_inorder_mc", 32'(mc[0]), 2);
    check_status("unord_inorder_pass", 1, ST_PASS);

    // Extra store to an unknown address
    do_start();
    wr(32'd200, 32'd0);
    check_status("extra_ignored", 2, ST_RUN);
    check_status("noextra_badaddr", 0, ST_BADADDR);
    check("noextra_fa", fa[0], 200);
    check_status("noextra_badaddr_unord", 1, ST_BADADDR);
    wr(32'd96, 32'd7);
    wr(32'd100, 32'd25);
    check_status("extra_pass", 2, ST_PASS);

    // Timeout with no writes
    do_start();
    tick(TO - 1);
    check("to_edge_busy", 32'(busy[0]), 1);
    tick();
    check_status("timeout", 0, ST_TIMEOUT);
    check("timeout_cc", 32'(cc[0]), TO);
    check("timeout_fa", fa[0], 0);
    check("timeout_fd", fd[0], 0);
    check_status("timeout_unord", 1, ST_TIMEOUT);

    // Final match on the timeout cycle wins
    do_start();
    wr(32'd96, 32'd7);
    tick(TO - 2);
    check("late_cc", 32'(cc[0]), TO - 1);
    wr(32'd100, 32'd25);
    check_status("late_pass", 0, ST_PASS);
    check("late_pass_cc", 32'(cc[0]), TO);
    check_status("late_pass_unord", 1, ST_PASS);

    // Byte-enable masking
    do_clear();
    load(3'd0, 32'd100, 32'h0000_0019);
    do_start();
    wr(32'd100, 32'hFFFF_FF19, 4'b0001);
    check_status("be_mask_pass", 0, ST_PASS);
    do_start();
    wr(32'd100, 32'hFFFF_FF18, 4'b0001);
    check_status("be_mask_baddata", 0, ST_BADDATA);
    check("be_mask_fd", fd[0], 32'hFFFF_FF18);
    do_start();
    wr(32'd100, 32'hDEAD_BEEF, 4'b0000);
    check_status("be_zero_pass", 0, ST_PASS);

    // Loads during RUN are ignored
    do_start();
    load(3'd1, 32'd300, 32'd1);
    wr(32'd100, 32'd25);
    check_status("run_load_ignored", 0, ST_PASS);

    // Empty table
    do_clear();
    do_start();
    tick();
    check_status("no_expect", 0, ST_NOEXP);
    wr(32'd100, 32'd25);
    check_status("wr_outside_run", 0, ST_NOEXP);
    check("wr_outside_mc", 32'(mc[0]), 0);

    // Reset mid-run drops the table
    load(3'd0, 32'd100, 32'd25);
    do_start();
    tick(3);
    rst = 1'b1; tick(); rst = 1'b0;
    check("rst_busy", 32'(busy[0]), 0);
    check_status("rst_status", 0, 32'h0);
    check("rst_cc", 32'(cc[0]), 0);
    do_start();
    check_status("rst_table_lost", 0, ST_NOEXP);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
